// File: rtl/pingpong_pkg.sv
// Shared constants and the read-return FIFO entry type for the ping-pong line buffer.
package pingpong_pkg;

  localparam int FIFO_DEPTH    = 4;
  localparam int BANKS         = 2;
  localparam int PP_DATA_WIDTH = 32;
  localparam int FIFO_CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [PP_DATA_WIDTH-1:0] data;
    logic                     last;
  } fifo_entry_t;

  // Number of reads still travelling through the RAM pipe (at most two).
  function automatic logic [FIFO_CNT_W-1:0] count_ones2(input logic [1:0] v);
    return FIFO_CNT_W'(v[0]) + FIFO_CNT_W'(v[1]);
  endfunction

  function automatic logic [FIFO_PTR_W-1:0] fifo_ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/pingpong_line_buf_ctrl_fifo.sv
// Small synchronous FIFO holding returned RAM words; head is read straight from the
// entry registers so out_data never depends on the RAM output timing.
module sync_fifo_small
  import pingpong_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  fifo_entry_t           push_data_i,
  input  logic                  pop_i,
  output fifo_entry_t           head_o,
  output logic                  valid_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  fifo_entry_t             mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0]   count_q, count_d;
  logic                    do_push, do_pop;

  assign do_push = push_i && (count_q < FIFO_CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = fifo_ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = fifo_ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Entries are cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/pingpong_line_buf_ctrl.sv
// Ping-pong line buffer sequencer: the writer fills one RAM half while the reader drains
// the other through a short return pipe and a 4-entry output FIFO.
module pingpong_line_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = PP_DATA_WIDTH,
  parameter int LINE_LEN   = 128,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [1:0]            bank_full,
  output logic                  line_wr_done,
  output logic                  line_rd_done
);

  localparam int            CW       = ADDR_WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LINE_LEN - 1);

  logic                  wr_bank_q, wr_bank_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [BANKS-1:0]      bank_full_q, bank_full_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0] last_pipe_q, last_pipe_d;

  logic                  accept, wr_last;
  logic                  issue, rd_last;
  logic                  pop;
  logic [BANKS-1:0]      set_mask, clr_mask;
  logic [FIFO_CNT_W-1:0] inflight;
  logic [FIFO_CNT_W:0]   occupancy;

  fifo_entry_t           ret_entry;
  fifo_entry_t           fifo_head;
  logic                  ret_valid;
  logic                  fifo_valid;
  logic [FIFO_CNT_W-1:0] fifo_count;

  // Write side is purely combinational so a word reaches the RAM in its accept cycle.
  assign in_ready    = ~bank_full_q[wr_bank_q];
  assign accept      = in_valid & in_ready;
  assign wr_last     = accept && (wr_cnt_q == CNT_LAST);
  assign ram_wr_en   = accept;
  assign ram_wr_addr = {wr_bank_q, wr_cnt_q};
  assign ram_wr_data = in_data;

  // Reads are only issued when a FIFO slot is guaranteed for the returning word.
  assign inflight    = count_ones2(2'(vld_pipe_q));
  assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = bank_full_q[rd_bank_q] && (occupancy < (FIFO_CNT_W+1)'(FIFO_DEPTH));
  assign rd_last     = issue && (rd_cnt_q == CNT_LAST);
  assign ram_rd_addr = {rd_bank_q, rd_cnt_q};

  assign set_mask = wr_last ? (BANKS'(1) << wr_bank_q) : '0;
  assign clr_mask = rd_last ? (BANKS'(1) << rd_bank_q) : '0;

  assign ret_valid      = vld_pipe_q[RD_LATENCY-1];
  assign ret_entry.data = ram_rd_data;
  assign ret_entry.last = last_pipe_q[RD_LATENCY-1];

  assign pop = fifo_valid & out_ready;

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    bank_full_d = (bank_full_q | set_mask) & ~clr_mask;
    wr_done_d   = wr_last;
    rd_done_d   = pop & fifo_head.last;
    vld_pipe_d  = RD_LATENCY'({vld_pipe_q, issue});
    last_pipe_d = RD_LATENCY'({last_pipe_q, rd_last});

    if (accept) begin
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d  = wr_cnt_q + 1'b1;
      end
    end

    // The bank is released at its final issue; the RAM already holds the address.
    if (issue) begin
      if (rd_last) begin
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_cnt_d  = rd_cnt_q + 1'b1;
      end
    end

    if (flush) begin
      wr_bank_d   = 1'b0;
      wr_cnt_d    = '0;
      rd_bank_d   = 1'b0;
      rd_cnt_d    = '0;
      bank_full_d = '0;
      wr_done_d   = 1'b0;
      rd_done_d   = 1'b0;
      vld_pipe_d  = '0;
      last_pipe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      bank_full_q <= '0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      bank_full_q <= bank_full_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  sync_fifo_small u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (ret_valid),
    .push_data_i (ret_entry),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign out_valid    = fifo_valid;
  assign out_data     = fifo_head.data;
  assign bank_full    = bank_full_q;
  assign line_wr_done = wr_done_q;
  assign line_rd_done = rd_done_q;

endmodule

// File: tb/tb_pingpong_line_buf_ctrl.sv
// Directed + randomized bench: a queue-of-lines model predicts the output stream, and a
// second instance with a two-cycle RAM checks latency independence of the data.
module tb_pingpong_line_buf_ctrl;

  localparam int LL = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, ram_wr_en, line_wr_done, line_rd_done;
  logic [31:0] out_data, ram_wr_data, ram_rd_data;
  logic [7:0]  ram_wr_addr, ram_rd_addr;
  logic [1:0]  bank_full;

  logic        in_ready2, out_valid2, ram_wr_en2, line_wr_done2, line_rd_done2;
  logic [31:0] out_data2, ram_wr_data2, ram_rd_data2;
  logic [7:0]  ram_wr_addr2, ram_rd_addr2;
  logic [1:0]  bank_full2;

  always #5 clk = ~clk;

  pingpong_line_buf_ctrl #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .bank_full(bank_full), .line_wr_done(line_wr_done), .line_rd_done(line_rd_done)
  );

  pingpong_line_buf_ctrl #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
    .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2), .ram_wr_data(ram_wr_data2),
    .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2),
    .bank_full(bank_full2), .line_wr_done(line_wr_done2), .line_rd_done(line_rd_done2)
  );

  // Behavioural RAMs: one with a single read register, one with an extra output register.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd1, rd2a, rd2b;
  always @(posedge clk) begin
    if (ram_wr_en) mem1[ram_wr_addr] <= ram_wr_data;
    rd1 <= mem1[ram_rd_addr];
  end
  always @(posedge clk) begin
    if (ram_wr_en2) mem2[ram_wr_addr2] <= ram_wr_data2;
    rd2a <= mem2[ram_rd_addr2];
    rd2b <= rd2a;
  end
  assign ram_rd_data  = rd1;
  assign ram_rd_data2 = rd2b;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted words collect into a partial line; a completed line
  // becomes expected output. Reset or flush discards everything not yet delivered.
  logic [31:0] part_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] q2[$];
  logic [31:0] exp_word;
  logic [7:0]  exp_addr;
  int cyc = 0, lines_w = 0, pops_in_line = 0, ps = 0;
  int n_acc = 0, n_pop = 0, n_wr_obs = 0, n_rd_obs = 0, n_wr2_obs = 0, n_rd2_obs = 0;
  int last_acc_cyc = 0, pop_at_acc = 0, first_ov1 = -1, first_ov2 = -1;
  bit exp_wr_done = 0, exp_rd_done = 0, cap2 = 0, has_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("line_wr_done", 64'(line_wr_done), 64'(rst_n ? exp_wr_done : 1'b0));
    check("line_rd_done", 64'(line_rd_done), 64'(rst_n ? exp_rd_done : 1'b0));
    check("fifo_count_le4", 64'(dut1.u_fifo.count_o <= 3'd4), 64'(1));
    exp_wr_done = 0;
    exp_rd_done = 0;
    if (line_wr_done) n_wr_obs++;
    if (line_rd_done) n_rd_obs++;
    if (out_valid  && first_ov1 < 0) first_ov1 = cyc;
    if (out_valid2 && first_ov2 < 0) first_ov2 = cyc;
    if (cap2) begin
      if (line_wr_done2) n_wr2_obs++;
      if (line_rd_done2) n_rd2_obs++;
      if (out_valid2 && out_ready && rst_n && !flush) q2.push_back(out_data2);
    end
    if (!rst_n || flush) begin
      part_q.delete();
      exp_q.delete();
      lines_w = 0;
      pops_in_line = 0;
    end else begin
      if (in_valid && in_ready) begin
        ps = part_q.size();
        exp_addr = {lines_w[0], 7'(ps)};
        check("wr_addr", 64'(ram_wr_addr), 64'(exp_addr));
        check("wr_bank_not_full", 64'(bank_full[ram_wr_addr[7]]), 64'(0));
        part_q.push_back(in_data);
        n_acc++;
        last_acc_cyc = cyc;
        pop_at_acc = n_pop;
        if (part_q.size() == LL) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          lines_w++;
          exp_wr_done = 1;
        end
      end
      if (out_valid && out_ready) begin
        has_exp = (exp_q.size() != 0);
        check("pop_has_expected", 64'(has_exp), 64'(1));
        if (has_exp) begin
          exp_word = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(exp_word));
        end
        n_pop++;
        pops_in_line++;
        if (pops_in_line == LL) begin
          pops_in_line = 0;
          exp_rd_done = 1;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("send_accepted", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && part_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check("drain_done", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_wr_en"},   64'(ram_wr_en),    64'(0));
    check({tag, "_out_valid"},   64'(out_valid),    64'(0));
    check({tag, "_wr_done"},     64'(line_wr_done), 64'(0));
    check({tag, "_rd_done"},     64'(line_rd_done), 64'(0));
    check({tag, "_ram_rd_addr"}, 64'(ram_rd_addr),  64'(0));
    check({tag, "_out_data"},    64'(out_data),     64'(0));
    check({tag, "_bank_full"},   64'(bank_full),    64'(0));
    check({tag, "_in_ready"},    64'(in_ready),     64'(1));
  endtask

  int nw, w0, r0, acc0, pop0;
  bit s3_done;

  initial begin
    // Reset values, during and after reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_during");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_after");

    // Single line, descending pattern, out_ready held high
    out_ready = 1'b1;
    first_ov1 = -1;
    first_ov2 = -1;
    cap2 = 1;
    w0 = n_wr_obs;
    r0 = n_rd_obs;
    for (int i = 0; i < LL; i++) send_word(32'hFFFF_FFFF - 32'(i));
    nw = last_acc_cyc + 1;
    check("s1_bank_full_01", 64'(bank_full), 64'(2'b01));
    wait_drain(600);
    repeat (4) @(posedge clk);
    #1;
    check("s1_wr_done_once", 64'(n_wr_obs - w0), 64'(1));
    check("s1_rd_done_once", 64'(n_rd_obs - r0), 64'(1));
    check("s1_bank_full_00", 64'(bank_full), 64'(0));
    check("s1_first_valid_lat1", 64'(first_ov1), 64'(nw + 2));
    check("s1_first_valid_lat2", 64'(first_ov2), 64'(nw + 3));
    check("s1_lat2_count", 64'(q2.size()), 64'(LL));
    for (int i = 0; i < LL && i < q2.size(); i++)
      check("s1_lat2_data", 64'(q2[i]), 64'(32'hFFFF_FFFF - 32'(i)));
    check("s1_lat2_wr_done", 64'(n_wr2_obs), 64'(1));
    check("s1_lat2_rd_done", 64'(n_rd2_obs), 64'(1));
    check("s1_lat2_bank_full", 64'(bank_full2), 64'(0));
    check("s1_lat2_in_ready", 64'(in_ready2), 64'(1));
    cap2 = 0;

    // Both banks full under backpressure; word 257 must wait for the reader
    out_ready = 1'b0;
    for (int i = 0; i < 2 * LL; i++) send_word($urandom());
    check("s2_bank_full_11", 64'(bank_full), 64'(2'b11));
    check("s2_in_ready_low", 64'(in_ready), 64'(0));
    acc0 = n_acc;
    pop0 = n_pop;
    in_valid = 1'b1;
    in_data  = 32'h2570_0257;
    repeat (20) begin
      @(negedge clk);
      check("s2_hold_in_ready", 64'(in_ready), 64'(0));
    end
    check("s2_no_accept_while_full", 64'(n_acc), 64'(acc0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_word(32'h2570_0257);
    check("s2_pops_before_accept", 64'((pop_at_acc - pop0) >= 124), 64'(1));
    for (int i = 0; i < LL - 1; i++) send_word($urandom());
    wait_drain(1200);

    // Random backpressure with a continuous writer over eight lines
    acc0 = n_acc;
    s3_done = 0;
    fork
      begin
        for (int i = 0; i < 8 * LL; i++) send_word($urandom());
        s3_done = 1;
      end
      begin
        while (!s3_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(1200);
    check("s3_words_accepted", 64'(n_acc - acc0), 64'(8 * LL));

    // Asynchronous reset at word 60 of the second line
    for (int i = 0; i < LL + 60; i++) send_word($urandom());
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s5_async");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("s5_wr_addr_zero", 64'(ram_wr_addr), 64'(0));
    r0 = n_rd_obs;
    for (int i = 0; i < LL; i++) send_word($urandom());
    wait_drain(600);
    check("s5_fresh_line_rd_done", 64'(n_rd_obs - r0), 64'(1));

    // Flush in the same cycle as the last-word accept
    for (int i = 0; i < LL - 1; i++) send_word($urandom());
    w0 = n_wr_obs;
    in_valid = 1'b1;
    in_data  = 32'hF1F1_F1F1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("s6_bank_full_00", 64'(bank_full), 64'(0));
    check("s6_wr_addr_zero", 64'(ram_wr_addr), 64'(0));
    check("s6_rd_addr_zero", 64'(ram_rd_addr), 64'(0));
    repeat (6) @(posedge clk);
    #1;
    check("s6_no_wr_done", 64'(n_wr_obs - w0), 64'(0));
    check("s6_no_output", 64'(out_valid), 64'(0));
    check("s6_bank_full_stays", 64'(bank_full), 64'(0));
    r0 = n_rd_obs;
    for (int i = 0; i < LL; i++) send_word($urandom());
    wait_drain(600);
    check("s6_after_flush_rd_done", 64'(n_rd_obs - r0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
